regwrite_scheduler: RTL and testbench

Write-back scheduler for the register-file write port. Arbitrates between the main control unit (ctl) and an auxiliary requester (aux: stack/exception sequencer) that both need to write the register file. Drives the 3-bit RegDst select consumed by the register-destination mux, plus RegWrite and the write data. Aux requests are buffered in a small FIFO, and a starvation guard stalls the control unit so that aux writes always drain.

---
 rtl/regwrite_scheduler.sv | 146 ++++++++++++++
 tb/tb_regwrite_scheduler.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regwrite_scheduler.sv
// rtl/regwrite_scheduler.sv - register-file write-back arbiter between ctl and a buffered aux requester
// Aux requests queue in a small FIFO; a starvation counter stalls ctl so aux entries always drain.
module regwrite_scheduler #(
   parameter int DATA_W     = 32,
   parameter int AUX_DEPTH  = 2,
   parameter int STARVE_LIM = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ctl_wr,
   input  logic [2:0]        ctl_dst,
   input  logic [DATA_W-1:0] ctl_data,
   output logic              ctl_stall,
   input  logic              aux_valid,
   output logic              aux_ready,
   input  logic [2:0]        aux_dst,
   input  logic [DATA_W-1:0] aux_data,
   output logic [2:0]        RegDst,
   output logic              RegWrite,
   output logic [DATA_W-1:0] wb_data,
   output logic              wb_src,
   output logic              err
);

   localparam int AW = $clog2(AUX_DEPTH);
   localparam int CW = $clog2(STARVE_LIM + 1);
   localparam logic [AW:0]   DEPTH_C = (AW+1)'(AUX_DEPTH);
   localparam logic [CW-1:0] LIM_C   = CW'(STARVE_LIM);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WR_CTL,
      S_WR_AUX
   } state_t;

   state_t state;

   logic [DATA_W+2:0] mem [AUX_DEPTH];
   logic [AW-1:0]     wptr;
   logic [AW-1:0]     rptr;
   logic [AW:0]       count;
   logic              full;
   logic [CW-1:0]     wait_cnt;

   logic              empty;
   logic              push_hs;
   logic              push;
   logic              aux_legal;
   logic              ctl_legal;
   logic              ctl_ok;
   logic              grant_aux;
   logic [2:0]        head_dst;
   logic [DATA_W-1:0] head_data;
   logic [AW:0]       count_nxt;
   logic [CW-1:0]     wait_nxt;
   logic              err_set;

   // Codes 110/111 are the only illegal RegDst selects.
   assign aux_legal = !(aux_dst[2] & aux_dst[1]);
   assign ctl_legal = !(ctl_dst[2] & ctl_dst[1]);

   assign aux_ready = !full;
   assign empty     = (count == '0);
   assign push_hs   = aux_valid && !full;
   assign push      = push_hs && aux_legal;

   // A dropped ctl request (stalled or illegal) never blocks the aux head.
   assign ctl_ok    = ctl_wr && !ctl_stall && ctl_legal;
   assign grant_aux = !empty && !ctl_ok;

   assign {head_dst, head_data} = mem[rptr];
   assign RegWrite = (state != S_IDLE);

   assign err_set = (ctl_wr && (ctl_stall || !ctl_legal)) || (push_hs && !aux_legal);

   always_comb begin
      count_nxt = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, grant_aux};
   end

   always_comb begin
      wait_nxt = wait_cnt;
      if (grant_aux || empty) begin
         wait_nxt = '0;
      end else if (wait_cnt != LIM_C) begin
         wait_nxt = wait_cnt + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr] <= {aux_dst, aux_data};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         RegDst    <= 3'b000;
         wb_data   <= '0;
         wb_src    <= 1'b0;
         ctl_stall <= 1'b0;
         err       <= 1'b0;
         wptr      <= '0;
         rptr      <= '0;
         count     <= '0;
         full      <= 1'b0;
         wait_cnt  <= '0;
      end else begin
         if (ctl_ok) begin
            state   <= S_WR_CTL;
            RegDst  <= ctl_dst;
            wb_data <= ctl_data;
            wb_src  <= 1'b0;
         end else if (grant_aux) begin
            state   <= S_WR_AUX;
            RegDst  <= head_dst;
            wb_data <= head_data;
            wb_src  <= 1'b1;
         end else begin
            state   <= S_IDLE;
         end

         if (push) begin
            wptr <= wptr + AW'(1);
         end
         if (grant_aux) begin
            rptr <= rptr + AW'(1);
         end
         count    <= count_nxt;
         full     <= (count_nxt == DEPTH_C);
         wait_cnt <= wait_nxt;

         // Stall lands together with the saturating count and lifts after the forced aux write.
         if (grant_aux) begin
            ctl_stall <= 1'b0;
         end else if (wait_nxt == LIM_C) begin
            ctl_stall <= 1'b1;
         end

         if (err_set) begin
            err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_regwrite_scheduler.sv
// tb/tb_regwrite_scheduler.sv - scoreboard bench for regwrite_scheduler
// Queue-based reference model predicts each write and its cycle; a monitor pops and compares.
module tb_regwrite_scheduler;

   localparam int DEPTH = 2;
   localparam int LIM   = 4;

   logic        clk;
   logic        reset;
   logic        ctl_wr;
   logic [2:0]  ctl_dst;
   logic [31:0] ctl_data;
   logic        ctl_stall;
   logic        aux_valid;
   logic        aux_ready;
   logic [2:0]  aux_dst;
   logic [31:0] aux_data;
   logic [2:0]  RegDst;
   logic        RegWrite;
   logic [31:0] wb_data;
   logic        wb_src;
   logic        err;

   regwrite_scheduler #(
      .DATA_W(32),
      .AUX_DEPTH(DEPTH),
      .STARVE_LIM(LIM)
   ) dut (
      .clk(clk),
      .reset(reset),
      .ctl_wr(ctl_wr),
      .ctl_dst(ctl_dst),
      .ctl_data(ctl_data),
      .ctl_stall(ctl_stall),
      .aux_valid(aux_valid),
      .aux_ready(aux_ready),
      .aux_dst(aux_dst),
      .aux_data(aux_data),
      .RegDst(RegDst),
      .RegWrite(RegWrite),
      .wb_data(wb_data),
      .wb_src(wb_src),
      .err(err)
   );

   typedef struct {
      int          cyc;
      logic [2:0]  dst;
      logic [31:0] data;
      logic        src;
   } wr_t;

   wr_t         exp_q[$];
   logic [34:0] fifo_m[$];
   int          m_wait;
   bit          m_stall;
   bit          m_err;
   logic [2:0]  last_dst;
   logic [31:0] last_data;
   int          cyc;
   int          vectors;
   int          miscompares;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic bit legal(input logic [2:0] d);
      return d <= 3'd5;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
      end
   endtask

   // Drive one cycle of stimulus and advance the reference model by one cycle.
   task automatic step(input bit cw, input logic [2:0] cd, input logic [31:0] cdat,
                       input bit av, input logic [2:0] ad, input logic [31:0] adat);
      bit          can_push;
      bit          aux_won;
      wr_t         w;
      logic [34:0] e;
      @(negedge clk);
      check("ctl_stall", {63'd0, ctl_stall}, {63'd0, m_stall});
      check("aux_ready", {63'd0, aux_ready}, {63'd0, fifo_m.size() < DEPTH});
      check("err", {63'd0, err}, {63'd0, m_err});
      ctl_wr    = cw;
      ctl_dst   = cd;
      ctl_data  = cdat;
      aux_valid = av;
      aux_dst   = ad;
      aux_data  = adat;

      can_push = fifo_m.size() < DEPTH;
      aux_won  = 1'b0;
      if (cw && (m_stall || !legal(cd))) m_err = 1'b1;
      if (cw && !m_stall && legal(cd)) begin
         w.cyc = cyc + 1; w.dst = cd; w.data = cdat; w.src = 1'b0;
         exp_q.push_back(w);
         if (fifo_m.size() == 0) m_wait = 0;
         else if (m_wait < LIM) m_wait = m_wait + 1;
      end else if (fifo_m.size() > 0) begin
         e = fifo_m.pop_front();
         w.cyc = cyc + 1; w.dst = e[34:32]; w.data = e[31:0]; w.src = 1'b1;
         exp_q.push_back(w);
         aux_won = 1'b1;
         m_wait  = 0;
      end else begin
         m_wait = 0;
      end
      if (aux_won) m_stall = 1'b0;
      else if (m_wait == LIM) m_stall = 1'b1;
      if (av && can_push) begin
         if (legal(ad)) fifo_m.push_back({ad, adat});
         else m_err = 1'b1;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset     = 1'b0;
      ctl_wr    = 1'b0;
      aux_valid = 1'b0;
      #1;
      check("rst_regwrite", {63'd0, RegWrite}, 64'd0);
      check("rst_regdst", {61'd0, RegDst}, 64'd0);
      check("rst_wb_data", {32'd0, wb_data}, 64'd0);
      check("rst_wb_src", {63'd0, wb_src}, 64'd0);
      check("rst_ctl_stall", {63'd0, ctl_stall}, 64'd0);
      check("rst_aux_ready", {63'd0, aux_ready}, 64'd1);
      check("rst_err", {63'd0, err}, 64'd0);
      fifo_m.delete();
      exp_q.delete();
      m_wait    = 0;
      m_stall   = 1'b0;
      m_err     = 1'b0;
      last_dst  = 3'd0;
      last_data = 32'd0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   // Monitor: every cycle either the head expected write is due or RegWrite must be low with held outputs.
   initial begin
      bit  due;
      wr_t w;
      forever begin
         @(posedge clk);
         #1;
         if (reset) begin
            due = 1'b0;
            if (exp_q.size() > 0) begin
               if (exp_q[0].cyc <= cyc) due = 1'b1;
            end
            check("regwrite", {63'd0, RegWrite}, {63'd0, due});
            if (due) begin
               w = exp_q.pop_front();
               check("regdst", {61'd0, RegDst}, {61'd0, w.dst});
               check("wb_data", {32'd0, wb_data}, {32'd0, w.data});
               check("wb_src", {63'd0, wb_src}, {63'd0, w.src});
               check("wr_cycle", 64'(cyc), 64'(w.cyc));
               last_dst  = w.dst;
               last_data = w.data;
            end else begin
               check("hold_regdst", {61'd0, RegDst}, {61'd0, last_dst});
               check("hold_wb_data", {32'd0, wb_data}, {32'd0, last_data});
            end
         end
      end
   end

   initial begin
      vectors     = 0;
      miscompares = 0;
      m_wait      = 0;
      m_stall     = 1'b0;
      m_err       = 1'b0;
      last_dst    = 3'd0;
      last_data   = 32'd0;
      reset       = 1'b0;
      ctl_wr      = 1'b0;
      ctl_dst     = 3'd0;
      ctl_data    = 32'd0;
      aux_valid   = 1'b0;
      aux_dst     = 3'd0;
      aux_data    = 32'd0;
      repeat (3) @(negedge clk);
      check("init_regwrite", {63'd0, RegWrite}, 64'd0);
      check("init_aux_ready", {63'd0, aux_ready}, 64'd1);
      reset = 1'b1;

      // Single ctl write.
      idle(1);
      step(1'b1, 3'b011, 32'h0000_1234, 1'b0, 3'd0, 32'd0);
      idle(3);

      // Single aux write, two cycles after the push.
      step(1'b0, 3'd0, 32'd0, 1'b1, 3'b010, 32'h0000_CAFE);
      idle(3);

      // Fill the FIFO behind ctl traffic, third aux held off until a pop.
      step(1'b1, 3'b001, 32'h11, 1'b1, 3'b010, 32'hA);
      step(1'b1, 3'b001, 32'h22, 1'b1, 3'b000, 32'hB);
      step(1'b1, 3'b001, 32'h33, 1'b1, 3'b001, 32'hC);
      step(1'b0, 3'd0, 32'd0, 1'b1, 3'b001, 32'hC);
      step(1'b0, 3'd0, 32'd0, 1'b1, 3'b001, 32'hC);
      idle(4);

      // Starvation: one queued aux entry against continuous ctl traffic.
      step(1'b1, 3'b000, 32'h100, 1'b1, 3'b011, 32'hBEEF);
      for (int i = 0; i < 8; i++) step(!m_stall, 3'b001, 32'h200 + i, 1'b0, 3'd0, 32'd0);
      idle(3);

      // Protocol-compliant random traffic; err must stay low.
      for (int i = 0; i < 400; i++) begin
         step(!m_stall && ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 5)), $urandom,
              $urandom_range(0, 1) == 1, 3'($urandom_range(0, 5)), $urandom);
      end
      idle(4);

      // Illegal ctl code, then ctl_wr while stalled.
      step(1'b1, 3'b111, 32'hDEAD, 1'b0, 3'd0, 32'd0);
      idle(2);
      step(1'b1, 3'b000, 32'h300, 1'b1, 3'b100, 32'h301);
      for (int i = 0; i < 6; i++) step(1'b1, 3'b101, 32'h310 + i, 1'b0, 3'd0, 32'd0);
      idle(3);

      // Reset while two aux entries are queued and a write is on the port.
      step(1'b1, 3'b001, 32'h400, 1'b1, 3'b010, 32'h401);
      step(1'b1, 3'b001, 32'h402, 1'b1, 3'b000, 32'h403);
      step(1'b1, 3'b001, 32'h404, 1'b0, 3'd0, 32'd0);
      do_reset();
      idle(6);

      // Unconstrained random traffic including violations and illegal codes.
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), $urandom,
              $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), $urandom);
      end
      idle(6);

      check("pending_writes", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
